data_cache_ctrl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache between the MIPS

---
 rtl/data_cache_ctrl.sv | 170 +++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for a single-cycle MIPS core.
// Read hits are answered combinationally; refills and stores stall the core.
module data_cache_ctrl #(
  parameter int NUM_LINES      = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int W  = $clog2(WORDS_PER_LINE);
  localparam int I  = $clog2(NUM_LINES);
  localparam int WB = (W == 0) ? 1 : W;
  localparam int TW = 30 - I - W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [31:0]     data_r [NUM_LINES][WORDS_PER_LINE];
  logic [TW-1:0]   tag_r  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_r;
  logic [WB-1:0]   count_r;

  logic [WB-1:0]   word_s;
  logic [I-1:0]    index_s;
  logic [TW-1:0]   tag_s;
  logic            hit_s;
  logic            last_beat_s;
  logic [31:0]     refill_addr_s;

  assign word_s        = (W == 0) ? '0 : WB'(cpu_addr[31:2]);
  assign index_s       = I'(cpu_addr >> (W + 2));
  assign tag_s         = TW'(cpu_addr >> (I + W + 2));
  assign hit_s         = valid_r[index_s] & (tag_r[index_s] == tag_s);
  assign last_beat_s   = (count_r == WB'(WORDS_PER_LINE - 1));
  assign refill_addr_s = {tag_s, index_s, {(W + 2){1'b0}}};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; stores take priority over loads
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (cpu_wr) begin
          state_next_s = WRITE;
        end else if (cpu_rd && !hit_s) begin
          state_next_s = REFILL;
        end else begin
          state_next_s = IDLE;
        end
      end
      REFILL: begin
        if (mem_ready && last_beat_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = REFILL;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          state_next_s = WDONE;
        end else begin
          state_next_s = WRITE;
        end
      end
      WDONE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // CPU-facing outputs: stall and hit data
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = 32'h0;
    case (state_r)
      IDLE:    cpu_stall = cpu_wr | (cpu_rd & ~hit_s);
      REFILL:  cpu_stall = 1'b1;
      WRITE:   cpu_stall = 1'b1;
      WDONE:   cpu_stall = 1'b0;
      default: cpu_stall = 1'b0;
    endcase
    if (hit_s) begin
      cpu_rdata = data_r[index_s][word_s];
    end else begin
      cpu_rdata = 32'h0;
    end
  end

  // Memory request registers, beat counter and valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      count_r   <= '0;
      valid_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cpu_wr) begin
            mem_wr    <= 1'b1;
            mem_addr  <= {cpu_addr[31:2], 2'b00};
            mem_wdata <= cpu_wdata;
          end else if (cpu_rd && !hit_s) begin
            mem_rd   <= 1'b1;
            mem_addr <= refill_addr_s;
            count_r  <= '0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (last_beat_s) begin
              mem_rd           <= 1'b0;
              valid_r[index_s] <= 1'b1;
            end else begin
              count_r  <= count_r + WB'(1);
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_wr <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays; never reset, qualified by valid_r
  always_ff @(posedge clk) begin
    if (state_r == REFILL && mem_ready) begin
      data_r[index_s][count_r] <= mem_rdata;
      if (last_beat_s) begin
        tag_r[index_s] <= tag_s;
      end
    end else if (state_r == WRITE && mem_ready && hit_s) begin
      data_r[index_s][word_s] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl: a flat memory plus a line-address cache model
// predict memory beats and load data; monitors compare as the DUT presents them.
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_rd, cpu_wr, cpu_stall, mem_rd, mem_wr, mem_ready;

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  logic [64:0] mem_q[$];   // {is_write, addr, wdata}
  logic [31:0] load_q[$];
  logic [31:0] phys[logic [31:0]];
  logic [31:0] refm[logic [31:0]];
  bit          mvalid[32];
  logic [31:0] mline[32];

  data_cache_ctrl #(.NUM_LINES(32), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : dflt(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory responder and memory-beat monitor
  initial begin
    int wc;
    int lat;
    logic [64:0] e;
    wc = 0;
    lat = 2;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!reset && (mem_rd || mem_wr)) begin
        wc++;
        if (wc >= lat) begin
          check("mem_rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
          if (mem_q.size() == 0) begin
            $display("FAIL unexpected_mem_beat: wr=%0d addr=%h", mem_wr, mem_addr);
            checks++;
            errors++;
          end else begin
            e = mem_q.pop_front();
            check("mem_kind", {31'd0, mem_wr}, {31'd0, e[64]});
            check("mem_addr", mem_addr, e[63:32]);
            if (e[64]) check("mem_wdata", mem_wdata, e[31:0]);
          end
          mem_ready = 1'b1;
          mem_rdata = mem_wr ? 32'h0 : phys_rd(mem_addr);
          if (mem_wr) phys[mem_addr] = mem_wdata;
          beats++;
          wc = 0;
          lat = $urandom_range(1, 3);
        end
      end else begin
        wc = 0;
      end
    end
  end

  // Load-data monitor: a load retires on the cycle stall is low
  always @(negedge clk) begin
    if (!reset && cpu_rd && !cpu_wr && !cpu_stall) begin
      if (load_q.size() == 0) begin
        $display("FAIL unexpected_load_retire: addr=%h rdata=%h", cpu_addr, cpu_rdata);
        checks++;
        errors++;
      end else begin
        check("load_data", cpu_rdata, load_q.pop_front());
      end
    end
  end

  task automatic finish_req(input bit exp_stall, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    check({nm, "_first_stall"}, {31'd0, cpu_stall}, {31'd0, exp_stall});
    while (cpu_stall && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (cpu_stall) flag({nm, "_timeout"});
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a);
    logic [31:0] line;
    int idx;
    bit h;
    line = a & ~32'hF;
    idx  = int'((a >> 4) & 32'd31);
    h    = mvalid[idx] && (mline[idx] == line);
    if (!h) begin
      for (int k = 0; k < 4; k++) mem_q.push_back({1'b0, line + 32'(4 * k), 32'd0});
      mvalid[idx] = 1'b1;
      mline[idx]  = line;
    end
    load_q.push_back(ref_rd(a & ~32'h3));
    cpu_addr = a;
    cpu_rd   = 1'b1;
    cpu_wr   = 1'b0;
    finish_req(!h, "load");
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit both);
    mem_q.push_back({1'b1, a & ~32'h3, d});
    refm[a & ~32'h3] = d;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    cpu_rd    = both;
    finish_req(1'b1, "store");
  endtask

  initial begin
    int n;
    int b0;
    logic [31:0] a;
    int r;
    reset = 1'b1;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      phys[32'h40 + 32'(4 * k)] = 32'h11 * 32'(k + 1);
      refm[32'h40 + 32'(4 * k)] = 32'h11 * 32'(k + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_stall", {31'd0, cpu_stall}, 32'd0);
    check("reset_rdata", cpu_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_load(32'h44);                     // cold miss, 4 beats, data 0x22
    do_load(32'h48);                     // same-cycle hit
    do_store(32'h44, 32'hDEADBEEF, 1'b0);
    do_load(32'h44);
    do_store(32'h1000, 32'hCAFEF00D, 1'b0);
    do_load(32'h1000);                   // no-allocate: still a miss
    do_load(32'h240);                    // conflicts with index 4
    do_load(32'h40);

    // Reset in the middle of a refill of 0x40
    do_load(32'h240);
    mem_q.push_back({1'b0, 32'h40, 32'd0});
    mem_q.push_back({1'b0, 32'h44, 32'd0});
    b0 = beats;
    cpu_addr = 32'h40;
    cpu_rd = 1'b1;
    n = 0;
    while (beats < b0 + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (beats < b0 + 2) flag("abort_refill_timeout");
    #1;
    reset = 1'b1;
    #1;
    check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    cpu_rd = 1'b0;
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_queue_drained", 32'(mem_q.size()), 32'd0);
    do_load(32'h40);                     // full 4-beat refill again

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 3) << 9) | 32'($urandom_range(0, 3) << 4) |
          32'($urandom_range(0, 3) << 2) | 32'($urandom_range(0, 3));
      if (r < 6) begin
        do_load(a);
      end else if (r < 9) begin
        do_store(a, $urandom, r == 8);
      end else begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    check("final_mem_q_empty", 32'(mem_q.size()), 32'd0);
    check("final_load_q_empty", 32'(load_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
